mpu_operand_feeder: RTL and testbench

// - Upstream sequencer for shift_fsm. Turns one tile command into the downstream c_valid/ab_valid stream.
// - Per command: optionally collects ml C rows into a local buffer, then bursts them back-to-back.
// - Then streams cmd_k A/B beats and pulses done. The C burst must be back-to-back because the

---
 rtl/mpu_feeder_pkg.sv | 24 ++
 rtl/mpu_row_buf.sv | 37 +++
 rtl/mpu_operand_feeder.sv | 158 +++++++++++++++
 tb/tb_mpu_operand_feeder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_feeder_pkg.sv
// Shared types and helpers for the MPU operand feeder: FSM state encoding,
// default-configuration widths and the cmd_k saturation helper.
package mpu_feeder_pkg;

  localparam int unsigned ML_DEF   = 2;
  localparam int unsigned EW_DEF   = 16;
  localparam int unsigned KMAX_DEF = 16;
  localparam int unsigned RW       = ML_DEF * EW_DEF;
  localparam int unsigned KW       = $clog2(KMAX_DEF + 1);

  typedef enum logic [2:0] {
    STARTUP,
    IDLE,
    FILL_C,
    WAKE,
    BURST_C,
    STREAM_AB
  } state_t;

  function automatic int unsigned clamp_k(input int unsigned k, input int unsigned kmax);
    return (k > kmax) ? kmax : k;
  endfunction

endpackage

// File: rtl/mpu_row_buf.sv
// ml-entry C row buffer: rows written by slot pointer, read by slot pointer,
// full once every slot has been written since the last clear.
module mpu_row_buf #(
  parameter int ml = 2,
  parameter int RW = 32,
  localparam int PW = (ml > 1) ? $clog2(ml) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_ptr,
  input  logic [RW-1:0] wr_data,
  input  logic [PW-1:0] rd_ptr,
  output logic [RW-1:0] rd_data,
  output logic          full
);

  logic [RW-1:0] mem [ml];
  logic [ml-1:0] held;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem  <= '{default: '0};
      held <= '0;
    end else if (clr) begin
      held <= '0;
    end else if (wr_en) begin
      mem[wr_ptr]  <= wr_data;
      held[wr_ptr] <= 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = &held;

endmodule

// File: rtl/mpu_operand_feeder.sv
// Upstream sequencer for shift_fsm: collects C rows, bursts them after a wake
// beat, then streams cmd_k A/B beats and pulses done.
module mpu_operand_feeder
  import mpu_feeder_pkg::*;
#(
  parameter int ml   = 2,
  parameter int EW   = 16,
  parameter int KMAX = 16,
  localparam int ROW_W = ml * EW,
  localparam int K_W   = $clog2(KMAX + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ld_c,
  input  logic [K_W-1:0]   cmd_k,
  input  logic             c_in_valid,
  output logic             c_in_ready,
  input  logic [ROW_W-1:0] c_in_data,
  input  logic             ab_in_valid,
  output logic             ab_in_ready,
  input  logic [ROW_W-1:0] a_in_data,
  input  logic [ROW_W-1:0] b_in_data,
  output logic             c_valid,
  output logic [ROW_W-1:0] c_data,
  output logic             ab_valid,
  output logic [ROW_W-1:0] a_data,
  output logic [ROW_W-1:0] b_data,
  output logic             busy,
  output logic             done
);

  localparam int PW = (ml > 1) ? $clog2(ml) : 1;
  localparam logic [PW-1:0] LAST_ROW = PW'(ml - 1);

  state_t state, next_state;
  logic [PW-1:0]    su_cnt, wr_ptr, burst_cnt, rd_ptr;
  logic [K_W-1:0]   k_lat, k_sat, beat_cnt;
  logic             cmd_acc, wr_en, fill_last, burst_last, ab_acc, beat_last, full;
  logic [ROW_W-1:0] rd_data, c_data_d;
  logic             c_valid_d, done_d;

  mpu_row_buf #(.ml(ml), .RW(ROW_W)) u_row_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cmd_acc),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr),
    .wr_data (c_in_data),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data),
    .full    (full)
  );

  assign k_sat       = K_W'(clamp_k(32'(cmd_k), KMAX));
  // Holding off during done keeps the next accept one cycle after the pulse.
  assign cmd_ready   = (state == IDLE) && !done;
  assign c_in_ready  = (state == FILL_C) && !full;
  assign ab_in_ready = (state == STREAM_AB);
  assign busy        = (state != IDLE);
  assign cmd_acc     = cmd_valid && cmd_ready;
  assign wr_en       = c_in_valid && c_in_ready;
  assign ab_acc      = ab_in_valid && ab_in_ready;
  assign fill_last   = wr_en && (wr_ptr == LAST_ROW);
  assign burst_last  = (burst_cnt == LAST_ROW);
  assign beat_last   = (beat_cnt == k_lat - 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= STARTUP;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      STARTUP:   if (su_cnt == LAST_ROW) next_state = IDLE;
      IDLE: begin
        if (cmd_acc) begin
          if (cmd_ld_c)        next_state = FILL_C;
          else if (k_sat != 0) next_state = STREAM_AB;
        end
      end
      FILL_C:    if (fill_last) next_state = WAKE;
      WAKE:      next_state = BURST_C;
      BURST_C:   if (burst_last) next_state = (k_lat != 0) ? STREAM_AB : IDLE;
      STREAM_AB: if (ab_acc && beat_last) next_state = IDLE;
      default:   next_state = STARTUP;
    endcase
  end

  // Next-cycle values for the registered outputs: each C beat is prepared in
  // the cycle before the state it belongs to, so it shows during that state.
  always_comb begin
    c_valid_d = 1'b0;
    c_data_d  = '0;
    done_d    = 1'b0;
    rd_ptr    = '0;
    case (state)
      IDLE:      done_d = cmd_acc && !cmd_ld_c && (k_sat == 0);
      FILL_C:    c_valid_d = fill_last;
      WAKE: begin
        c_valid_d = 1'b1;
        c_data_d  = rd_data;
      end
      BURST_C: begin
        rd_ptr    = burst_cnt + 1'b1;
        c_valid_d = !burst_last;
        c_data_d  = rd_data;
        done_d    = burst_last && (k_lat == 0);
      end
      STREAM_AB: done_d = ab_acc && beat_last;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      su_cnt    <= '0;
      wr_ptr    <= '0;
      burst_cnt <= '0;
      beat_cnt  <= '0;
      k_lat     <= '0;
    end else begin
      if (state == STARTUP) su_cnt <= su_cnt + 1'b1;
      if (cmd_acc) begin
        k_lat     <= k_sat;
        wr_ptr    <= '0;
        burst_cnt <= '0;
        beat_cnt  <= '0;
      end
      if (wr_en)              wr_ptr    <= wr_ptr + 1'b1;
      if (state == BURST_C)   burst_cnt <= burst_cnt + 1'b1;
      if (ab_acc)             beat_cnt  <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_valid  <= 1'b0;
      c_data   <= '0;
      ab_valid <= 1'b0;
      a_data   <= '0;
      b_data   <= '0;
      done     <= 1'b0;
    end else begin
      c_valid  <= c_valid_d;
      ab_valid <= ab_acc;
      done     <= done_d;
      if (c_valid_d) c_data <= c_data_d;
      if (ab_acc) begin
        a_data <= a_in_data;
        b_data <= b_in_data;
      end
    end
  end

endmodule

// File: tb/tb_mpu_operand_feeder.sv
// Scoreboard bench for mpu_operand_feeder (ml=2, EW=8, KMAX=16): expected C
// rows and A/B beats are queued at drive time and popped as outputs appear.
`timescale 1ns/1ps
module tb_mpu_operand_feeder;

  localparam int ML = 2, EW = 8, KMAX = 16;
  localparam int RW = ML * EW;
  localparam int KW = $clog2(KMAX + 1);

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ld_c = 1'b0;
  logic [KW-1:0] cmd_k = '0;
  logic          c_in_valid = 1'b0, ab_in_valid = 1'b0;
  logic [RW-1:0] c_in_data = '0, a_in_data = '0, b_in_data = '0;
  logic          cmd_ready, c_in_ready, ab_in_ready, c_valid, ab_valid, busy, done;
  logic [RW-1:0] c_data, a_data, b_data;

  mpu_operand_feeder #(.ml(ML), .EW(EW), .KMAX(KMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld_c(cmd_ld_c), .cmd_k(cmd_k),
    .c_in_valid(c_in_valid), .c_in_ready(c_in_ready), .c_in_data(c_in_data),
    .ab_in_valid(ab_in_valid), .ab_in_ready(ab_in_ready),
    .a_in_data(a_in_data), .b_in_data(b_in_data),
    .c_valid(c_valid), .c_data(c_data), .ab_valid(ab_valid),
    .a_data(a_data), .b_data(b_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [RW-1:0]   c_q[$];
  logic [2*RW-1:0] ab_q[$];
  logic [RW-1:0]   exp_c;
  logic [2*RW-1:0] exp_ab;
  int cyc = 0, done_cnt = 0, c_cnt = 0, ab_cnt = 0, ab_rdy_cnt = 0;
  int c_cyc_q[$], ab_cyc_q[$], done_cyc_q[$];

  // Output monitor: pops the scoreboard on every valid beat.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (c_valid || ab_valid) begin
      tests++;
      if (c_valid && ab_valid) begin
        fails++;
        $display("FAIL both_valid: c_valid=1 ab_valid=1 at cycle %0d, required not both", cyc);
      end
    end
    if (c_valid) begin
      c_cnt++;
      c_cyc_q.push_back(cyc);
      tests++;
      if (c_q.size() == 0) begin
        fails++;
        $display("FAIL c_beat: unexpected c_data=%h at cycle %0d", c_data, cyc);
      end else begin
        exp_c = c_q.pop_front();
        if (c_data !== exp_c) begin
          fails++;
          $display("FAIL c_data: got %h required %h at cycle %0d", c_data, exp_c, cyc);
        end
      end
    end
    if (ab_valid) begin
      ab_cnt++;
      ab_cyc_q.push_back(cyc);
      tests++;
      if (ab_q.size() == 0) begin
        fails++;
        $display("FAIL ab_beat: unexpected a=%h b=%h at cycle %0d", a_data, b_data, cyc);
      end else begin
        exp_ab = ab_q.pop_front();
        if ({a_data, b_data} !== exp_ab) begin
          fails++;
          $display("FAIL ab_data: got %h required %h at cycle %0d", {a_data, b_data}, exp_ab, cyc);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
    end
    if (ab_in_ready) ab_rdy_cnt++;
  end

  task automatic issue(input logic ld, input logic [KW-1:0] k, output bit ok);
    int unsigned n = 0;
    cmd_valid = 1'b1; cmd_ld_c = ld; cmd_k = k;
    #1;
    while (!cmd_ready && n < 60) begin @(negedge clk); #1; n++; end
    ok = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_ld_c = 1'b0; cmd_k = '0;
  endtask

  task automatic drive_c_row(input logic [RW-1:0] d, input int gap, output bit ok);
    int unsigned n = 0;
    repeat (gap) @(negedge clk);
    c_in_valid = 1'b1; c_in_data = d;
    #1;
    while (!c_in_ready && n < 20) begin @(negedge clk); #1; n++; end
    ok = c_in_ready;
    @(negedge clk);
    c_in_valid = 1'b0;
  endtask

  task automatic drive_ab_beat(output bit ok);
    int unsigned n = 0;
    logic [RW-1:0] a, b;
    a = RW'($urandom); b = RW'($urandom);
    ab_in_valid = 1'b1; a_in_data = a; b_in_data = b;
    #1;
    while (!ab_in_ready && n < 20) begin @(negedge clk); #1; n++; end
    ok = ab_in_ready;
    if (ok) ab_q.push_back({a, b});
    @(negedge clk);
    ab_in_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    int unsigned n = 0;
    while (done_cnt == base && n < 40) begin @(negedge clk); n++; end
    ok = (done_cnt != base);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_logs();
    c_cyc_q.delete(); ab_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({c_valid, ab_valid, done, cmd_ready, c_in_ready, ab_in_ready} !== 6'b0 ||
        c_data !== '0 || a_data !== '0 || b_data !== '0) begin
      fails++;
      $display("FAIL reset_out: valids/ready=%b data=%h/%h/%h required all 0",
               {c_valid, ab_valid, done, cmd_ready, c_in_ready, ab_in_ready}, c_data, a_data, b_data);
    end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b required 1", busy); end
    reset_n = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL startup_c1: cmd_ready=%b required 0", cmd_ready); end
    @(posedge clk); #1;
    tests++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL startup_c2: cmd_ready=%b required 0", cmd_ready); end
    @(posedge clk); #1;
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL startup_c3: cmd_ready=%b required 1", cmd_ready); end
    tests++;
    if ({c_valid, ab_valid, done} !== 3'b0) begin
      fails++; $display("FAIL startup_out: c/ab/done=%b required 000", {c_valid, ab_valid, done});
    end
    @(negedge clk);
  endtask

  task automatic test_ld_c_k3();
    bit ok, all_ok;
    int base, ab0;
    base = done_cnt; ab0 = ab_cnt; clear_logs();
    c_q.push_back('0); c_q.push_back(16'h1111); c_q.push_back(16'h2222);
    issue(1'b1, 5'd3, all_ok);
    drive_c_row(16'h1111, 0, ok); all_ok &= ok;
    drive_c_row(16'h2222, 2, ok); all_ok &= ok;
    for (int i = 0; i < 3; i++) begin drive_ab_beat(ok); all_ok &= ok; end
    wait_done(base, ok); all_ok &= ok;
    tests++;
    if (!all_ok) begin fails++; $display("FAIL ldc_handshake: timeout got 0 required 1"); end
    tests++;
    if (c_cyc_q.size() != 3 || c_cyc_q[2] - c_cyc_q[0] != 2) begin
      fails++; $display("FAIL ldc_burst: %0d C beats spanning %0d cycles, required 3 over 2",
                        c_cyc_q.size(), c_cyc_q.size() == 3 ? c_cyc_q[2] - c_cyc_q[0] : -1);
    end
    tests++;
    if (ab_cnt - ab0 != 3 || done_cnt - base != 1) begin
      fails++; $display("FAIL ldc_counts: ab=%0d done=%0d required 3 and 1", ab_cnt - ab0, done_cnt - base);
    end
    tests++;
    if (ab_cyc_q.size() != 3 || done_cyc_q.size() != 1 || done_cyc_q[0] != ab_cyc_q[2]) begin
      fails++; $display("FAIL ldc_done_time: done cycles=%0d required with 3rd ab beat", done_cyc_q.size());
    end
  endtask

  task automatic test_ab_gaps();
    bit ok;
    int base, c0;
    logic [4:0] pat;
    logic [RW-1:0] a, b;
    pat = 5'b11101;
    base = done_cnt; c0 = c_cnt; clear_logs();
    issue(1'b0, 5'd4, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL gaps_accept: cmd_ready got 0 required 1"); end
    for (int i = 0; i < 5; i++) begin
      a = RW'($urandom); b = RW'($urandom);
      ab_in_valid = pat[i]; a_in_data = a; b_in_data = b;
      #1;
      if (pat[i]) begin
        tests++;
        if (ab_in_ready !== 1'b1) begin fails++; $display("FAIL gaps_ready: beat %0d ready=%b required 1", i, ab_in_ready); end
        ab_q.push_back({a, b});
      end
      @(negedge clk);
    end
    ab_in_valid = 1'b0;
    wait_done(base, ok);
    tests++;
    if (ab_cyc_q.size() != 4 || ab_cyc_q[1] - ab_cyc_q[0] != 2 || ab_cyc_q[3] - ab_cyc_q[1] != 2) begin
      fails++; $display("FAIL gaps_pattern: %0d ab beats, required 4 in pattern 1,0,1,1,1", ab_cyc_q.size());
    end
    tests++;
    if (done_cyc_q.size() != 1 || ab_cyc_q.size() != 4 || done_cyc_q[0] != ab_cyc_q[3]) begin
      fails++; $display("FAIL gaps_done: done count %0d, required 1 with 4th beat", done_cyc_q.size());
    end
    tests++;
    if (c_cnt != c0) begin fails++; $display("FAIL gaps_no_c: c beats=%0d required 0", c_cnt - c0); end
  endtask

  task automatic test_c_only();
    bit ok, all_ok;
    int base, rdy0, ab0;
    base = done_cnt; rdy0 = ab_rdy_cnt; ab0 = ab_cnt; clear_logs();
    c_q.push_back('0); c_q.push_back(16'h5A5A); c_q.push_back(16'hC3C3);
    issue(1'b1, 5'd0, all_ok);
    drive_c_row(16'h5A5A, 0, ok); all_ok &= ok;
    drive_c_row(16'hC3C3, 1, ok); all_ok &= ok;
    wait_done(base, ok); all_ok &= ok;
    tests++;
    if (!all_ok) begin fails++; $display("FAIL conly_handshake: timeout got 0 required 1"); end
    tests++;
    if (c_cyc_q.size() != 3 || c_cyc_q[2] - c_cyc_q[0] != 2 || done_cyc_q.size() != 1 ||
        done_cyc_q[0] != c_cyc_q[2] + 1) begin
      fails++; $display("FAIL conly_timing: c beats=%0d dones=%0d, required 3 then done next cycle",
                        c_cyc_q.size(), done_cyc_q.size());
    end
    tests++;
    if (ab_rdy_cnt != rdy0 || ab_cnt != ab0) begin
      fails++; $display("FAIL conly_no_ab: ab_in_ready cycles=%0d ab beats=%0d required 0",
                        ab_rdy_cnt - rdy0, ab_cnt - ab0);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok, all_ok;
    int base, c0;
    int unsigned n = 0;
    clear_logs();
    c_q.push_back('0); c_q.push_back(16'hAAAA); c_q.push_back(16'hBBBB);
    issue(1'b1, 5'd2, all_ok);
    drive_c_row(16'hAAAA, 0, ok); all_ok &= ok;
    drive_c_row(16'hBBBB, 0, ok); all_ok &= ok;
    while (!(c_valid && c_data == 16'hBBBB) && n < 10) begin @(negedge clk); n++; end
    tests++;
    if (!(c_valid && c_data == 16'hBBBB) || !all_ok) begin
      fails++; $display("FAIL midrst_reach: c_data=%h required BBBB in burst", c_data);
    end
    base = done_cnt;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({c_valid, ab_valid, done} !== 3'b0 || c_data !== '0 || a_data !== '0 || b_data !== '0) begin
      fails++; $display("FAIL midrst_out: c/ab/done=%b c_data=%h required all 0", {c_valid, ab_valid, done}, c_data);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    c_q.delete();
    issue(1'b1, 5'd1, all_ok);
    tests++;
    if (done_cnt != base) begin fails++; $display("FAIL midrst_done: dones=%0d required 0", done_cnt - base); end
    drive_c_row(16'h3333, 0, ok); all_ok &= ok;
    c0 = c_cnt;
    repeat (4) @(negedge clk);
    #1;
    tests++;
    if (c_cnt != c0 || c_in_ready !== 1'b1) begin
      fails++; $display("FAIL midrst_refill: c beats=%0d c_in_ready=%b required 0 and 1", c_cnt - c0, c_in_ready);
    end
    c_q.push_back('0); c_q.push_back(16'h3333); c_q.push_back(16'h4444);
    @(negedge clk);
    drive_c_row(16'h4444, 0, ok); all_ok &= ok;
    drive_ab_beat(ok); all_ok &= ok;
    wait_done(base, ok); all_ok &= ok;
    tests++;
    if (!all_ok || done_cnt - base != 1 || c_q.size() != 0 || ab_q.size() != 0) begin
      fails++; $display("FAIL midrst_next: dones=%0d pending c=%0d ab=%0d required 1,0,0",
                        done_cnt - base, c_q.size(), ab_q.size());
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int base, ab0, rdy;
    logic [RW-1:0] a, b;
    base = done_cnt; ab0 = ab_cnt; rdy = 0; clear_logs();
    issue(1'b0, 5'd20, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL sat_accept: cmd_ready got 0 required 1"); end
    for (int i = 0; i < 22; i++) begin
      a = RW'($urandom); b = RW'($urandom);
      ab_in_valid = 1'b1; a_in_data = a; b_in_data = b;
      #1;
      if (ab_in_ready) rdy++;
      if (i < KMAX) ab_q.push_back({a, b});
      @(negedge clk);
    end
    ab_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (rdy != KMAX || ab_cnt - ab0 != KMAX) begin
      fails++; $display("FAIL sat_beats: ready=%0d beats=%0d required 16", rdy, ab_cnt - ab0);
    end
    tests++;
    if (done_cyc_q.size() != 1 || ab_cyc_q.size() != KMAX || done_cyc_q[0] != ab_cyc_q[KMAX-1]) begin
      fails++; $display("FAIL sat_done: dones=%0d required 1 with 16th beat", done_cyc_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = done_cnt; clear_logs();
    cmd_valid = 1'b1; cmd_ld_c = 1'b0; cmd_k = '0;
    repeat (6) @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (done_cnt - base != 3 || done_cyc_q.size() != 3 ||
        done_cyc_q[1] - done_cyc_q[0] != 2 || done_cyc_q[2] - done_cyc_q[1] != 2) begin
      fails++; $display("FAIL b2b_done: dones=%0d required 3 spaced 2 cycles", done_cnt - base);
    end
    tests++;
    if (c_q.size() != 0 || ab_q.size() != 0) begin
      fails++; $display("FAIL final_drain: pending c=%0d ab=%0d required 0", c_q.size(), ab_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ld_c_k3();
    test_ab_gaps();
    test_c_only();
    test_reset_mid_burst();
    test_saturate();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
